// File: rtl/fetch_sequencer.sv
// Fetch-stage PC control sequencer: RET/RTI two-word pop, interrupt entry
// (drain, two-word PC push, ISR jump), hazard stalls and jump/branch redirects.
// Optional build macro FETCH_SEQ_PERF_EN adds a stall_cnt performance counter.
module fetch_sequencer #(
    parameter int unsigned DRAIN = 2,
    parameter int unsigned W     = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           stall_hz,
    input  logic           jmp_D,
    input  logic           ret_D,
    input  logic           rti_D,
    input  logic           branch_E,
    input  logic           intr,
    input  logic           pop_valid,
    input  logic           push_ack,
    input  logic [2*W-1:0] pc,
    output logic           pc_enb,
    output logic           flush,
    output logic           branch,
    output logic [1:0]     jump_sel,
    output logic [1:0]     pop_l_h,
    output logic           push_req,
    output logic [W-1:0]   push_data,
    output logic           intr_ack,
    output logic           in_isr,
`ifdef FETCH_SEQ_PERF_EN
    output logic [31:0]    stall_cnt,
`endif
    output logic           busy
);

    typedef enum logic [2:0] {
        StRun, StPopH, StPopL, StRetGo, StDrain, StPushL, StPushH, StIntGo
    } state_e;

    state_e         state_q, state_d;
    logic           pending_q, pending_d;
    logic           in_isr_q, in_isr_d;
    logic           rti_q, rti_d;
    logic [2:0]     cnt_q, cnt_d;
    logic [2*W-1:0] save_q, save_d;

    // Next-state and Mealy outputs; outputs are forced to defaults while rst is high.
    always_comb begin
        state_d   = state_q;
        in_isr_d  = in_isr_q;
        rti_d     = rti_q;
        cnt_d     = cnt_q;
        save_d    = save_q;
        pc_enb    = 1'b1;
        flush     = 1'b0;
        branch    = 1'b0;
        jump_sel  = 2'b00;
        pop_l_h   = 2'b00;
        push_req  = 1'b0;
        push_data = '0;
        intr_ack  = 1'b0;
        unique case (state_q)
            StRun: begin
                if (branch_E) begin
                    branch = 1'b1;
                end else if (pending_q && !in_isr_q) begin
                    flush   = 1'b1;
                    pc_enb  = 1'b0;
                    save_d  = pc;
                    cnt_d   = 3'd0;
                    state_d = StDrain;
                end else if (ret_D || rti_D) begin
                    flush   = 1'b1;
                    pc_enb  = 1'b0;
                    rti_d   = rti_D;
                    state_d = StPopH;
                end else if (jmp_D) begin
                    jump_sel = 2'b01;
                    flush    = 1'b1;
                end else if (stall_hz) begin
                    pc_enb = 1'b0;
                end
            end
            StPopH: begin
                flush  = 1'b1;
                pc_enb = 1'b0;
                if (pop_valid) begin
                    pop_l_h = 2'b10;
                    state_d = StPopL;
                end
            end
            StPopL: begin
                flush  = 1'b1;
                pc_enb = 1'b0;
                if (pop_valid) begin
                    pop_l_h = 2'b11;
                    state_d = StRetGo;
                end
            end
            StRetGo: begin
                jump_sel = 2'b11;
                flush    = 1'b1;
                if (rti_q) in_isr_d = 1'b0;
                state_d  = StRun;
            end
            StDrain: begin
                flush  = 1'b1;
                pc_enb = 1'b0;
                cnt_d  = cnt_q + 3'd1;
                if (cnt_q == 3'(DRAIN - 1)) state_d = StPushL;
            end
            StPushL: begin
                push_req  = 1'b1;
                push_data = save_q[W-1:0];
                flush     = 1'b1;
                pc_enb    = 1'b0;
                if (push_ack) state_d = StPushH;
            end
            StPushH: begin
                push_req  = 1'b1;
                push_data = save_q[2*W-1:W];
                flush     = 1'b1;
                pc_enb    = 1'b0;
                if (push_ack) state_d = StIntGo;
            end
            StIntGo: begin
                jump_sel = 2'b10;
                flush    = 1'b1;
                intr_ack = 1'b1;
                in_isr_d = 1'b1;
                state_d  = StRun;
            end
            default: state_d = StRun;
        endcase
        // Ack wins over a coincident request so a held level cannot re-arm immediately.
        pending_d = intr_ack ? 1'b0 : (pending_q | intr);
        if (rst) begin
            pc_enb    = 1'b1;
            flush     = 1'b0;
            branch    = 1'b0;
            jump_sel  = 2'b00;
            pop_l_h   = 2'b00;
            push_req  = 1'b0;
            push_data = '0;
            intr_ack  = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StRun;
            pending_q <= 1'b0;
            in_isr_q  <= 1'b0;
            rti_q     <= 1'b0;
            cnt_q     <= 3'd0;
            save_q    <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            in_isr_q  <= in_isr_d;
            rti_q     <= rti_d;
            cnt_q     <= cnt_d;
            save_q    <= save_d;
        end
    end

    assign in_isr = in_isr_q;
    assign busy   = (state_q != StRun) && !rst;

`ifdef FETCH_SEQ_PERF_EN
    logic [31:0] stall_cnt_q;

    // Count every cycle the PC is held; wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) stall_cnt_q <= 32'd0;
        else if (!pc_enb) stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: phase-counter reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_fetch_sequencer;

    localparam int unsigned DRAIN = 2;
    localparam int unsigned W     = 16;

    logic        clk = 1'b0;
    logic        rst, stall_hz, jmp_D, ret_D, rti_D, branch_E, intr, pop_valid, push_ack;
    logic [31:0] pc;
    logic        pc_enb, flush, branch, push_req, intr_ack, in_isr, busy;
    logic [1:0]  jump_sel, pop_l_h;
    logic [15:0] push_data;
`ifdef FETCH_SEQ_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] sc0;
    logic [31:0] m_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    fetch_sequencer #(.DRAIN(DRAIN), .W(W)) dut (
        .clk(clk), .rst(rst), .stall_hz(stall_hz), .jmp_D(jmp_D), .ret_D(ret_D),
        .rti_D(rti_D), .branch_E(branch_E), .intr(intr), .pop_valid(pop_valid),
        .push_ack(push_ack), .pc(pc), .pc_enb(pc_enb), .flush(flush), .branch(branch),
        .jump_sel(jump_sel), .pop_l_h(pop_l_h), .push_req(push_req),
        .push_data(push_data), .intr_ack(intr_ack), .in_isr(in_isr),
`ifdef FETCH_SEQ_PERF_EN
        .stall_cnt(stall_cnt),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: sequences tracked as remaining-work counters, not states.
    logic        m_on = 1'b0;
    logic        m_pending, m_in_isr, m_is_rti, m_ret_go, m_int_go;
    int          m_pop_left, m_drain_left, m_push_left;
    logic [31:0] m_save;

    typedef struct packed {
        logic        pc_enb;
        logic        flush;
        logic        branch;
        logic [1:0]  jump_sel;
        logic [1:0]  pop_l_h;
        logic        push_req;
        logic [15:0] push_data;
        logic        intr_ack;
        logic        busy;
        logic        in_isr;
    } exp_t;

    function automatic exp_t expect_now();
        exp_t e;
        e = '{pc_enb: 1'b1, default: '0};
        e.in_isr = m_in_isr;
        if (rst) return e;
        e.busy = (m_pop_left != 0) || m_ret_go || (m_drain_left != 0) ||
                 (m_push_left != 0) || m_int_go;
        if (m_pop_left != 0) begin
            e.flush = 1'b1; e.pc_enb = 1'b0;
            if (pop_valid) e.pop_l_h = (m_pop_left == 2) ? 2'b10 : 2'b11;
        end else if (m_ret_go) begin
            e.jump_sel = 2'b11; e.flush = 1'b1;
        end else if (m_drain_left != 0) begin
            e.flush = 1'b1; e.pc_enb = 1'b0;
        end else if (m_push_left != 0) begin
            e.push_req = 1'b1; e.flush = 1'b1; e.pc_enb = 1'b0;
            e.push_data = (m_push_left == 2) ? m_save[15:0] : m_save[31:16];
        end else if (m_int_go) begin
            e.jump_sel = 2'b10; e.flush = 1'b1; e.intr_ack = 1'b1;
        end else if (branch_E) begin
            e.branch = 1'b1;
        end else if (m_pending && !m_in_isr) begin
            e.flush = 1'b1; e.pc_enb = 1'b0;
        end else if (ret_D || rti_D) begin
            e.flush = 1'b1; e.pc_enb = 1'b0;
        end else if (jmp_D) begin
            e.jump_sel = 2'b01; e.flush = 1'b1;
        end else if (stall_hz) begin
            e.pc_enb = 1'b0;
        end
        return e;
    endfunction

    // Model update at the active edge.
    always @(posedge clk) begin
        exp_t e;
        e = expect_now();
        m_on <= 1'b1;
        if (rst) begin
            m_pending = 0; m_in_isr = 0; m_is_rti = 0; m_ret_go = 0; m_int_go = 0;
            m_pop_left = 0; m_drain_left = 0; m_push_left = 0; m_save = 0;
`ifdef FETCH_SEQ_PERF_EN
            m_cnt = 0;
`endif
        end else begin
`ifdef FETCH_SEQ_PERF_EN
            if (!e.pc_enb) m_cnt = m_cnt + 1;
`endif
            if (m_pop_left != 0) begin
                if (pop_valid) begin
                    m_pop_left = m_pop_left - 1;
                    if (m_pop_left == 0) m_ret_go = 1;
                end
            end else if (m_ret_go) begin
                m_ret_go = 0;
                if (m_is_rti) m_in_isr = 0;
            end else if (m_drain_left != 0) begin
                m_drain_left = m_drain_left - 1;
                if (m_drain_left == 0) m_push_left = 2;
            end else if (m_push_left != 0) begin
                if (push_ack) begin
                    m_push_left = m_push_left - 1;
                    if (m_push_left == 0) m_int_go = 1;
                end
            end else if (m_int_go) begin
                m_int_go = 0; m_in_isr = 1;
            end else if (!branch_E) begin
                if (m_pending && !m_in_isr) begin
                    m_save = pc; m_drain_left = DRAIN;
                end else if (ret_D || rti_D) begin
                    m_pop_left = 2; m_is_rti = rti_D;
                end
            end
            m_pending = e.intr_ack ? 1'b0 : (m_pending | intr);
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_on) begin
            exp_t e;
            e = expect_now();
            check("cycle_outputs",
                  {5'd0, pc_enb, flush, branch, jump_sel, pop_l_h, push_req, push_data,
                   intr_ack, busy, in_isr}, {5'd0, e});
`ifdef FETCH_SEQ_PERF_EN
            check("cycle_stall_cnt", stall_cnt, m_cnt);
`endif
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        rst = 1; stall_hz = 0; jmp_D = 0; ret_D = 0; rti_D = 0; branch_E = 0;
        intr = 0; pop_valid = 0; push_ack = 0; pc = 32'h0000_0100;
        nxt(); nxt();
        rst = 0;
        @(negedge clk);
        check("reset_pc_enb", pc_enb, 1); check("reset_busy", busy, 0);
        check("reset_in_isr", in_isr, 0); check("reset_push_req", push_req, 0);
        nxt();

        // Hazard stall for 4 cycles.
        stall_hz = 1;
`ifdef FETCH_SEQ_PERF_EN
        sc0 = stall_cnt;
`endif
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_pc_enb", pc_enb, 0); check("stall_flush", flush, 0);
            nxt();
        end
        stall_hz = 0;
        @(negedge clk);
        check("stall_release", pc_enb, 1);
`ifdef FETCH_SEQ_PERF_EN
        check("stall_cnt_delta", stall_cnt - sc0, 4);
`endif
        nxt();

        // Jump.
        jmp_D = 1;
        @(negedge clk);
        check("jmp_sel", jump_sel, 2'b01); check("jmp_flush", flush, 1);
        check("jmp_pc_enb", pc_enb, 1);
        nxt(); jmp_D = 0;

        // RET with delayed pop beats.
        ret_D = 1;
        @(negedge clk); check("ret_flush", flush, 1); check("ret_pc_enb", pc_enb, 0);
        nxt(); ret_D = 0;
        @(negedge clk); check("pop_wait", pop_l_h, 2'b00); check("pop_busy", busy, 1);
        nxt(); nxt();
        pop_valid = 1;
        @(negedge clk); check("pop_high", pop_l_h, 2'b10);
        nxt(); pop_valid = 0;
        @(negedge clk); check("pop_gap", pop_l_h, 2'b00); check("pop_gap_flush", flush, 1);
        nxt(); pop_valid = 1;
        @(negedge clk); check("pop_low", pop_l_h, 2'b11);
        nxt(); pop_valid = 0;
        @(negedge clk); check("ret_go_sel", jump_sel, 2'b11); check("ret_go_flush", flush, 1);
        nxt();
        @(negedge clk); check("ret_done_busy", busy, 0); check("ret_done_sel", jump_sel, 0);
        nxt();

        // Interrupt entry.
        pc = 32'h0001_0042; intr = 1;
        @(negedge clk); check("int_req_cycle", flush, 0);
        nxt(); intr = 0;
        @(negedge clk); check("int_start_flush", flush, 1); check("int_start_busy", busy, 0);
        nxt();
        @(negedge clk); check("drain1", busy, 1); check("drain1_push", push_req, 0);
        nxt();
        @(negedge clk); check("drain2_push", push_req, 0);
        nxt(); push_ack = 1;
        @(negedge clk); check("push_lo_req", push_req, 1); check("push_lo", push_data, 16'h0042);
        nxt();
        @(negedge clk); check("push_hi", push_data, 16'h0001);
        nxt(); push_ack = 0;
        @(negedge clk); check("isr_sel", jump_sel, 2'b10); check("isr_ack", intr_ack, 1);
        nxt();
        @(negedge clk); check("isr_in_isr", in_isr, 1); check("isr_ack_pulse", intr_ack, 0);
        nxt();

        // Interrupt while in ISR, then RTI.
        intr = 1;
        @(negedge clk); check("nest_blocked", busy, 0);
        nxt(); intr = 0;
        @(negedge clk); check("nest_no_flush", flush, 0);
        nxt(); rti_D = 1;
        @(negedge clk); check("rti_flush", flush, 1);
        nxt(); rti_D = 0; pop_valid = 1;
        @(negedge clk); check("rti_pop_h", pop_l_h, 2'b10);
        nxt();
        @(negedge clk); check("rti_pop_l", pop_l_h, 2'b11);
        nxt(); pop_valid = 0;
        @(negedge clk); check("rti_go_sel", jump_sel, 2'b11); check("rti_go_isr", in_isr, 1);
        nxt(); pc = 32'hABCD_1234;
        @(negedge clk); check("rti_cleared", in_isr, 0); check("pend_enter", pc_enb, 0);
        nxt();
        @(negedge clk); check("pend_drain", busy, 1);
        nxt(); nxt();
        @(negedge clk); check("hold_req", push_req, 1); check("hold_data", push_data, 16'h1234);
        nxt();
        @(negedge clk); check("hold_req2", push_req, 1);
        nxt(); rst = 1;
        @(negedge clk); check("rst_gate_push", push_req, 0);
        nxt(); rst = 0;
        @(negedge clk);
        check("rst_mid_busy", busy, 0); check("rst_mid_push", push_req, 0);
        check("rst_mid_pc_enb", pc_enb, 1); check("rst_mid_in_isr", in_isr, 0);
        nxt();

        // branch_E, intr and ret_D together.
        branch_E = 1; intr = 1; ret_D = 1; pc = 32'h0002_0010;
        @(negedge clk); check("combo_branch", branch, 1); check("combo_pc_enb", pc_enb, 1);
        check("combo_flush", flush, 0);
        nxt(); branch_E = 0; intr = 0; ret_D = 0;
        @(negedge clk); check("combo_int_start", flush, 1); check("combo_busy0", busy, 0);
        nxt();
        @(negedge clk); check("combo_drain", busy, 1); check("combo_no_pop", pop_l_h, 0);
        nxt(); push_ack = 1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (intr_ack) seen = 1;
            nxt();
        end
        check("combo_isr_seen", seen, 1);
        push_ack = 0;
        @(negedge clk); check("combo_in_isr", in_isr, 1);
        nxt();

        // Reset clears in_isr.
        rst = 1;
        nxt(); rst = 0;
        @(negedge clk); check("rst_in_isr", in_isr, 0);
        nxt(); nxt();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Control FSM that drives the fetch stage's PC-control inputs: pc_enb, flush, branch, jump_sel and pop_l_h.
- Sequences the two-word return-address pop for RET/RTI.
- Sequences interrupt entry: drain, two-word PC push, jump to ISR.
- Also handles hazard stalls and jump/branch redirects.
- Sits between decode/execute/writeback control signals and the fetch stage.

Parameters:
- DRAIN, 2, number of flush cycles inserted before the interrupt push (pipeline drain); legal range 1..7.
- W, 16, data word width; the PC is 2*W.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- stall_hz  in  1  load-use hazard from decode; hold the PC.
- jmp_D  in  1  unconditional jump decoded; target is Rdst_D.
- ret_D  in  1  RET decoded in decode.
- rti_D  in  1  RTI decoded in decode; handled as RET, plus clears in_isr.
- branch_E  in  1  conditional branch resolved taken in execute.
- intr  in  1  external interrupt request, level.
- pop_valid  in  1  the word popped from stack is on WD this cycle.
- push_ack  in  1  stack accepted the pushed word this cycle.
- pc  in  2*W  current PC from fetch.
- pc_enb  out  1  PC register enable.
- flush  out  1  replace the fetched instruction with NOP.
- branch  out  1  selects Rdst_E, overriding jump_sel.
- jump_sel  out  2  00 = pc+1, 01 = Rdst_D, 10 = ISR, 11 = return address.
- pop_l_h  out  2  bit1 = capture enable; bit0: 0 = high word, 1 = low word.
- push_req  out  1  request to push push_data.
- push_data  out  W  word to push.
- intr_ack  out  1  one-cycle pulse on the ISR jump.
- in_isr  out  1  set on ISR entry, cleared on RTI completion.
- busy  out  1  asserted whenever state != RUN.

Behaviour:
- States: RUN, POP_H, POP_L, RET_GO, DRAIN_S, PUSH_L, PUSH_H, INT_GO.
- Default outputs every cycle:
  - pc_enb=1, flush=0, branch=0, jump_sel=00, pop_l_h=00, push_req=0, intr_ack=0.
- Reset:
  - state=RUN, pending=0, in_isr=0, drain counter=0, saved PC=0.
  - All outputs take their defaults; busy=0.
- RUN, priority order (highest first):
  - branch_E: branch=1, pc_enb=1; fetch injects NOP itself; stay in RUN.
  - pending & !in_isr: flush=1, pc_enb=0, latch pc into save reg, counter=0, go to DRAIN_S.
  - ret_D|rti_D: flush=1, pc_enb=0, go to POP_H; remember rti.
  - jmp_D: jump_sel=01, flush=1.
  - stall_hz: pc_enb=0.
  - Otherwise: defaults.
- pending flag:
  - Set by intr in any state.
  - Cleared on the intr_ack cycle.
  - A request that arrives mid-sequence is serviced on return to RUN.
- POP_H: flush=1, pc_enb=0.
  - On pop_valid: pop_l_h=10, go to POP_L.
  - Otherwise wait indefinitely.
- POP_L: flush=1, pc_enb=0.
  - On pop_valid: pop_l_h=11, go to RET_GO.
- RET_GO: jump_sel=11, pc_enb=1, flush=1.
  - If the sequence was started by rti: in_isr<=0.
  - Go to RUN.
- DRAIN_S: flush=1, pc_enb=0, counter++.
  - When counter==DRAIN-1, go to PUSH_L.
- PUSH_L: push_req=1, push_data=save[W-1:0]; flush=1, pc_enb=0.
  - Advance on push_ack; otherwise hold the request.
- PUSH_H: same as PUSH_L with save[2W-1:W].
  - The low word is pushed first, so a pop returns the high word first; this matches POP_H.
- INT_GO: jump_sel=10, pc_enb=1, flush=1, intr_ack=1, in_isr<=1, pending<=0; go to RUN.
- branch_E outside RUN is ignored.
  - The decoder never issues a branch while busy, because flush keeps the pipe empty.
- Reset asserted in any state returns to RUN within the same edge; a partial pop or push is abandoned.
- Interrupts are not nested while in_isr=1; pending is retained until RTI completes.

Optional Feature:
- Macro FETCH_SEQ_PERF_EN.
- When defined, adds output stall_cnt [31:0]:
  - Counts every cycle with pc_enb=0.
  - Wraps at 2^32; cleared by rst.
- When undefined, the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset mid-PUSH_L, then release → state=RUN, push_req=0, busy=0, in_isr=0, pc_enb=1.
- ret_D in RUN; pop_valid asserted 3 cycles later, then again 2 cycles after that →
  - pop_l_h=10 then 11 on exactly those cycles;
  - jump_sel=11 for one cycle, then RUN;
  - flush=1 on every busy cycle.
- pc=0x0001_0042, intr pulse, DRAIN=2, push_ack asserted immediately →
  - 2 drain cycles;
  - pushes 0x0042 then 0x0001;
  - jump_sel=10 and intr_ack=1 on one cycle; in_isr=1.
- Same cycle branch_E=1, intr=1, ret_D=1 → branch=1 that cycle; the next cycle enters DRAIN_S; ret_D is ignored.
- intr while in_isr=1, then rti_D with two pop_valid beats → in_isr clears on RET_GO; the next RUN cycle enters DRAIN_S.
- stall_hz held 4 cycles with jmp_D=0 → pc_enb=0 for 4 cycles, flush=0; with FETCH_SEQ_PERF_EN, stall_cnt increases by 4.
